instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the single-cycle MIPS core. It holds a loadable word-addressed instruction memory and a program counter, and presents each fetched instruction to the decode stage. The instruction is presented both whole and pre-split into op/funct/rs/rt/rd, the fields consumed by the control decoder. A valid/ready handshake lets decode stall fetch, and a small run/halt state machine governs loading, execution and out-of-range termination.

## Interface
- RESET_PC, 32'h0000_3000, address of word 0 of the instruction memory and the PC after reset/start
- DEPTH, 1024, instruction memory size in 32-bit words (power of two)
- ADDR_W, 10, log2(DEPTH)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; the only clock is clk
- im_we  in  1  loader write strobe, honoured only in IDLE
- im_waddr  in  ADDR_W  loader word index
- im_wdata  in  32  loader word
- start  in  1  single-cycle pulse; from IDLE or HALT, begin fetching at RESET_PC
- instr_ready  in  1  decode accepts the current instruction
- br_taken  in  1  redirect request (only with IFETCH_BRANCH_EN)
- br_target  in  32  redirect address (only with IFETCH_BRANCH_EN)
- instr_valid  out  1  instr/pc_out hold a valid instruction
- instr  out  32  fetched word
- op  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- funct  out  6  instr[5:0]
- pc_out  out  32  address of instr
- running  out  1  state == RUN
- halted  out  1  state == HALT
- err  out  1  sticky out-of-range flag
- fetch_cnt  out  32  count of accepted instructions

## Operation
- States:
  - IDLE (reset state): loader writes are honoured and the PC is parked. start -> RUN.
  - RUN: fetching proceeds. An out-of-range fetch -> HALT. start is ignored.
  - HALT: no fetch. start -> RUN.
- Entering RUN from IDLE or HALT via start: pc <= RESET_PC, err <= 0, fetch_cnt <= 0, instr_valid <= 0.
- Word index: idx = (pc - RESET_PC) >> 2. The PC's low two bits are always 00.
- Out of range: (pc - RESET_PC) >> 2 >= DEPTH, including addresses below RESET_PC, which wrap to large values.
- Fetch enable: state == RUN and (!instr_valid or instr_ready).
- On a fetch enable with idx in range:
  - instr <= mem[idx], pc_out <= pc, instr_valid <= 1
  - pc <= pc + 4, mod 2^32
- On a fetch enable with idx out of range: instr_valid <= 0, err <= 1, state <= HALT.
- Handshake: while instr_valid=1 and instr_ready=0, instr and pc_out hold stable.
- fetch_cnt increments on each cycle with instr_valid && instr_ready and wraps at 2^32.
- The output fields are combinational slices of the instr register.
- Loader writes outside IDLE are dropped. Memory contents survive reset and start; they are never cleared.

## Timing
- Reset values: instr_valid=0, instr=0, pc_out=0, running=0, halted=0, err=0, fetch_cnt=0, state=IDLE, pc=RESET_PC.
- Assertion of rst_n=0 takes effect immediately, at any time including mid-run.
- Memory read is synchronous.
- Startup latency: start sampled at edge N gives running=1 after edge N, and the first instr_valid=1 (pc_out=RESET_PC) after edge N+1.
- Throughput: one instruction per cycle while instr_ready=1.
- Halt: the out-of-range fetch edge sets halted=1 and err=1. An instruction already accepted in that same cycle still counts toward fetch_cnt.
- im_we together with start in IDLE: the write lands at that edge. The first fetch, one edge later, observes the written data.
- start in RUN: no effect.

## Configuration
- IFETCH_BRANCH_EN defined:
  - In RUN, br_taken=1 takes priority over fetch enable at that edge: instr_valid <= 0 (flushing the presented instruction, which is not counted even if instr_ready=1), pc <= {br_target[31:2], 2'b00}.
  - The next fetch occurs one edge later. If the target is out of range, that next fetch halts.
  - br_taken is ignored outside RUN.
- IFETCH_BRANCH_EN undefined: the br_taken and br_target ports are absent, and the PC advances only by +4.

## Test plan
- Load mem[0..2] = 0x00221820, 0x00221822, 0x00221825; pulse start; hold instr_ready=1.
  - Expect pc_out 0x3000/0x3004/0x3008 on consecutive cycles.
  - First word: op=0, rs=1, rt=2, rd=3, funct=0x20.
  - fetch_cnt reaches 3.
- Hold instr_ready=0 for 4 cycles after the first instr_valid: instr stays 0x00221820, pc_out stays 0x3000, fetch_cnt stays 0. Release: the sequence resumes at 0x3004.
- With DEPTH=4, run all words with ready=1: the fetch at pc 0x3010 gives halted=1, err=1, instr_valid=0, fetch_cnt=4. start then restarts at 0x3000 with err=0.
- Assert rst_n=0 mid-run at pc 0x3008: all outputs return to reset values immediately. Memory keeps its contents, so restarting re-reads 0x00221820.
- Assert im_we in RUN to word 0: there is no effect on later fetches of word 0.
- IFETCH_BRANCH_EN: br_taken with br_target=0x3006 while 0x3000 is presented: that instruction is flushed and not counted. The next valid instruction has pc_out=0x3004.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch unit for the single-cycle MIPS core.
//
// Holds a loadable, word-addressed instruction memory and the program
// counter, and presents each fetched word to decode with a valid/ready
// handshake.  A small IDLE/RUN/HALT machine governs loading, execution and
// termination on an out-of-range fetch.
//
// Optional feature: define IFETCH_BRANCH_EN to add the br_taken/br_target
// redirect ports.  Without it the PC only advances by +4.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   im_we/im_waddr/im_wdata loader write port (honoured only in IDLE)
//   start                   pulse: from IDLE or HALT, begin at RESET_PC
//   instr_ready             decode accepts the presented instruction
//   br_taken/br_target      redirect request (IFETCH_BRANCH_EN only)
//   instr_valid/instr/pc_out presented instruction and its address
//   op/rs/rt/rd/funct       field slices of instr
//   running/halted          state == RUN / state == HALT
//   err                     sticky out-of-range flag (cleared by start)
//   fetch_cnt               number of accepted instructions
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 1024,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              im_we,
    input  logic [ADDR_W-1:0] im_waddr,
    input  logic [31:0]       im_wdata,
    input  logic              start,
    input  logic              instr_ready,
`ifdef IFETCH_BRANCH_EN
    input  logic              br_taken,
    input  logic [31:0]       br_target,
`endif
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [5:0]        op,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [31:0]       pc_out,
    output logic              running,
    output logic              halted,
    output logic              err,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t            state, state_next;
    logic [31:0]       pc;
    logic [31:0]       mem [DEPTH];

    logic [31:0]       offset;
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              start_run;
    logic              fetch_en;
    logic              flush;
    logic              unused_bits;

    // Addresses below RESET_PC wrap to huge offsets, so one unsigned
    // compare of the upper bits catches both ends of the window.
    assign offset      = pc - RESET_PC;
    assign idx         = offset[ADDR_W+1:2];
    assign in_range    = (offset[31:ADDR_W+2] == '0);
    assign unused_bits = ^offset[1:0];

    assign op      = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign running = (state == RUN);
    assign halted  = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignment for every register so all state
            // updates at an edge see the pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_next = state;
        start_run  = 1'b0;
        fetch_en   = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_next = RUN;
                    start_run  = 1'b1;
                end
            end
            RUN: begin
`ifdef IFETCH_BRANCH_EN
                // A redirect wins over fetch: the presented word is dropped.
                if (br_taken) flush = 1'b1;
                else
`endif
                if (!instr_valid || instr_ready) begin
                    fetch_en = 1'b1;
                    if (!in_range) state_next = HALT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the instruction memory has no reset; its contents survive rst_n
    // and start so a program loaded once can be rerun.
    always_ff @(posedge clk) begin
        if (im_we && state == IDLE) mem[im_waddr] <= im_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
            fetch_cnt   <= '0;
        end else if (start_run) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            err         <= 1'b0;
            fetch_cnt   <= '0;
        end else begin
            // A flushed instruction was never delivered, so it is not counted.
            if (instr_valid && instr_ready && !flush) fetch_cnt <= fetch_cnt + 32'd1;
`ifdef IFETCH_BRANCH_EN
            if (flush) begin
                instr_valid <= 1'b0;
                pc          <= {br_target[31:2], 2'b00};
            end else
`endif
            if (fetch_en) begin
                if (in_range) begin
                    instr       <= mem[idx];
                    pc_out      <= pc;
                    instr_valid <= 1'b1;
                    pc          <= pc + 32'd4;
                end else begin
                    instr_valid <= 1'b0;
                    err         <= 1'b1;
                end
            end
        end
    end

`ifdef IFETCH_BRANCH_EN
    logic unused_br;
    assign unused_br = ^br_target[1:0];
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch -- self-checking bench for instr_fetch.
// Uses a small memory (16 words) so out-of-range halts are reached quickly.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          DEPTH    = 16;
    localparam int          ADDR_W   = 4;
    localparam logic [31:0] W0 = 32'h0022_1820;
    localparam logic [31:0] W1 = 32'h0022_1822;
    localparam logic [31:0] W2 = 32'h0022_1825;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;
    logic              start;
    logic              instr_ready;
`ifdef IFETCH_BRANCH_EN
    logic              br_taken;
    logic [31:0]       br_target;
`endif
    logic              instr_valid;
    logic [31:0]       instr;
    logic [5:0]        op;
    logic [4:0]        rs, rt, rd;
    logic [5:0]        funct;
    logic [31:0]       pc_out;
    logic              running, halted, err;
    logic [31:0]       fetch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference copy of what the memory should hold.
    logic [31:0] model [DEPTH];

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .start(start), .instr_ready(instr_ready),
`ifdef IFETCH_BRANCH_EN
        .br_taken(br_taken), .br_target(br_target),
`endif
        .instr_valid(instr_valid), .instr(instr),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
        .pc_out(pc_out), .running(running), .halted(halted), .err(err),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({instr_valid, running, halted, err} !== 4'b0) begin
            n_bad++; $display("FAIL reset_flags got %b exp 0000", {instr_valid, running, halted, err});
        end
        n_cmp++;
        if ({instr, pc_out, fetch_cnt} !== 96'h0) begin
            n_bad++; $display("FAIL reset_regs got %h/%h/%h exp 0/0/0", instr, pc_out, fetch_cnt);
        end
        rst_n = 1'b1;
        step();
    endtask

    // Random program, random ready pattern, run to the out-of-range halt.
    // Word 0 is written in the same cycle as start to check the write lands.
    task automatic test_random();
        int n;
        int cyc;
        logic rdy;
        for (int i = 1; i <= DEPTH; i++) begin
            int a = i % DEPTH;
            model[a] = $urandom;
            im_we = 1'b1; im_waddr = ADDR_W'(a); im_wdata = model[a];
            if (a == 0) start = 1'b1;
            step();
        end
        im_we = 1'b0; start = 1'b0;
        n_cmp++;
        if ({running, instr_valid} !== 2'b10) begin
            n_bad++; $display("FAIL rnd_start got run/valid %b exp 10", {running, instr_valid});
        end
        n = 0;
        cyc = 0;
        while (cyc < 400) begin
            rdy = 1'($urandom_range(0, 1));
            instr_ready = rdy;
            if (instr_valid && rdy) n++;
            step();
            cyc++;
            if (halted) break;
            n_cmp++;
            if (fetch_cnt !== 32'(n)) begin
                n_bad++; $display("FAIL rnd_cnt got %0d exp %0d", fetch_cnt, n);
            end
            if (instr_valid) begin
                n_cmp++;
                if (n >= DEPTH) begin
                    n_bad++; $display("FAIL rnd_overrun got valid at pc %h exp halt", pc_out);
                end else if (instr !== model[n] || pc_out !== RESET_PC + 32'(4 * n) ||
                             op !== model[n][31:26] || rs !== model[n][25:21] ||
                             rt !== model[n][20:16] || rd !== model[n][15:11] ||
                             funct !== model[n][5:0]) begin
                    n_bad++;
                    $display("FAIL rnd_fetch got %h@%h exp %h@%h", instr, pc_out, model[n],
                             RESET_PC + 32'(4 * n));
                end
            end
        end
        n_cmp++;
        if ({halted, err, instr_valid, running} !== 4'b1100 || fetch_cnt !== 32'(DEPTH)) begin
            n_bad++;
            $display("FAIL rnd_halt got h/e/v/r %b cnt %0d exp 1100 cnt %0d",
                     {halted, err, instr_valid, running}, fetch_cnt, DEPTH);
        end
        instr_ready = 1'b0;
    endtask

    task automatic load_directed();
        logic [31:0] w [3];
        w[0] = W0; w[1] = W1; w[2] = W2;
        for (int i = 0; i < 3; i++) begin
            model[i] = w[i];
            im_we = 1'b1; im_waddr = ADDR_W'(i); im_wdata = w[i];
            step();
        end
        im_we = 1'b0;
    endtask

    task automatic test_directed();
        do_reset();
        load_directed();
        pulse_start();
        n_cmp++;
        if ({running, halted, instr_valid} !== 3'b100) begin
            n_bad++; $display("FAIL dir_latency got r/h/v %b exp 100", {running, halted, instr_valid});
        end
        instr_ready = 1'b1;
        step();
        n_cmp++;
        if ({instr_valid, pc_out, instr} !== {1'b1, RESET_PC, W0}) begin
            n_bad++; $display("FAIL dir_first got %b %h %h exp 1 %h %h", instr_valid, pc_out, instr, RESET_PC, W0);
        end
        n_cmp++;
        if ({op, rs, rt, rd, funct} !== {6'd0, 5'd1, 5'd2, 5'd3, 6'h20}) begin
            n_bad++; $display("FAIL dir_fields got op%0d rs%0d rt%0d rd%0d f%h exp 0 1 2 3 20", op, rs, rt, rd, funct);
        end
        step();
        n_cmp++;
        if ({instr_valid, pc_out, instr} !== {1'b1, RESET_PC + 32'd4, W1}) begin
            n_bad++; $display("FAIL dir_second got %b %h %h exp 1 3004 %h", instr_valid, pc_out, instr, W1);
        end
        step();
        n_cmp++;
        if ({instr_valid, pc_out, instr} !== {1'b1, RESET_PC + 32'd8, W2}) begin
            n_bad++; $display("FAIL dir_third got %b %h %h exp 1 3008 %h", instr_valid, pc_out, instr, W2);
        end
        step();
        n_cmp++;
        if (fetch_cnt !== 32'd3) begin
            n_bad++; $display("FAIL dir_cnt got %0d exp 3", fetch_cnt);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        instr_ready = 1'b0;
        pulse_start();
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({instr_valid, instr, pc_out, fetch_cnt} !== {1'b1, W0, RESET_PC, 32'd0}) begin
                n_bad++; $display("FAIL stall_hold got %b %h %h %0d exp 1 %h 3000 0",
                                  instr_valid, instr, pc_out, fetch_cnt, W0);
            end
        end
        instr_ready = 1'b1;
        step();
        n_cmp++;
        if ({instr_valid, pc_out, instr, fetch_cnt} !== {1'b1, RESET_PC + 32'd4, W1, 32'd1}) begin
            n_bad++; $display("FAIL stall_resume got %b %h %h %0d exp 1 3004 %h 1",
                              instr_valid, pc_out, instr, fetch_cnt, W1);
        end
        // start while running must not restart the sequence.
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if ({instr_valid, pc_out, fetch_cnt} !== {1'b1, RESET_PC + 32'd8, 32'd2}) begin
            n_bad++; $display("FAIL start_in_run got %b %h %0d exp 1 3008 2", instr_valid, pc_out, fetch_cnt);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        instr_ready = 1'b1;
        pulse_start();
        step(); step(); step();
        n_cmp++;
        if (pc_out !== RESET_PC + 32'd8) begin
            n_bad++; $display("FAIL mid_pre got pc %h exp 3008", pc_out);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({instr_valid, running, halted, err, instr, pc_out, fetch_cnt} !== '0) begin
            n_bad++; $display("FAIL mid_reset got v%b r%b h%b e%b %h %h %0d exp all 0",
                              instr_valid, running, halted, err, instr, pc_out, fetch_cnt);
        end
        #1;
        rst_n = 1'b1;
        step();
        pulse_start();
        step();
        n_cmp++;
        if ({instr_valid, pc_out, instr} !== {1'b1, RESET_PC, W0}) begin
            n_bad++; $display("FAIL mid_restart got %b %h %h exp 1 3000 %h", instr_valid, pc_out, instr, W0);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_write_in_run();
        int cyc;
        do_reset();
        instr_ready = 1'b1;
        pulse_start();
        im_we = 1'b1; im_waddr = '0; im_wdata = 32'hdead_beef;
        step();
        im_we = 1'b0;
        cyc = 0;
        while (!halted && cyc < 100) begin
            step();
            cyc++;
        end
        n_cmp++;
        if ({halted, err, instr_valid} !== 3'b110 || fetch_cnt !== 32'(DEPTH)) begin
            n_bad++; $display("FAIL wr_halt got h/e/v %b cnt %0d exp 110 cnt %0d",
                              {halted, err, instr_valid}, fetch_cnt, DEPTH);
        end
        pulse_start();
        n_cmp++;
        if ({running, halted, err, instr_valid, fetch_cnt} !== {4'b1000, 32'd0}) begin
            n_bad++; $display("FAIL restart got r/h/e/v %b cnt %0d exp 1000 0",
                              {running, halted, err, instr_valid}, fetch_cnt);
        end
        step();
        n_cmp++;
        if ({instr_valid, pc_out, instr} !== {1'b1, RESET_PC, W0}) begin
            n_bad++; $display("FAIL wr_dropped got %b %h %h exp 1 3000 %h", instr_valid, pc_out, instr, W0);
        end
        instr_ready = 1'b0;
    endtask

`ifdef IFETCH_BRANCH_EN
    task automatic test_branch();
        do_reset();
        instr_ready = 1'b1;
        pulse_start();
        step();
        br_taken = 1'b1; br_target = 32'h0000_3006;
        step();
        br_taken = 1'b0;
        n_cmp++;
        if ({instr_valid, fetch_cnt} !== {1'b0, 32'd0}) begin
            n_bad++; $display("FAIL br_flush got v%b cnt %0d exp 0 0", instr_valid, fetch_cnt);
        end
        step();
        n_cmp++;
        if ({instr_valid, pc_out, instr, fetch_cnt} !== {1'b1, RESET_PC + 32'd4, W1, 32'd0}) begin
            n_bad++; $display("FAIL br_target got %b %h %h %0d exp 1 3004 %h 0", instr_valid, pc_out, instr, fetch_cnt, W1);
        end
        br_taken = 1'b1; br_target = 32'h0000_2ffc;
        step();
        br_taken = 1'b0;
        step();
        n_cmp++;
        if ({halted, err, instr_valid} !== 3'b110) begin
            n_bad++; $display("FAIL br_oor got h/e/v %b exp 110", {halted, err, instr_valid});
        end
        instr_ready = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b1; im_we = 1'b0; im_waddr = '0; im_wdata = '0;
        start = 1'b0; instr_ready = 1'b0;
`ifdef IFETCH_BRANCH_EN
        br_taken = 1'b0; br_target = '0;
`endif
        #2;
        test_reset();
        test_random();
        test_directed();
        test_stall();
        test_reset_midrun();
        test_write_in_run();
`ifdef IFETCH_BRANCH_EN
        test_branch();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
